// File: rtl/auto_play_seq.sv
// ROM-driven auto player: emits synthetic key onset/release events for the piano path,
// with per-note lengths, selectable tempo, pause, stop and loop.
module auto_play_seq #(
  parameter int    NUM_SONGS   = 4,
  parameter int    SONG_DEPTH  = 128,
  parameter int    TICK_CYCLES = 12_500_000,
  parameter int    GAP_CYCLES  = 1_000_000,
  parameter string INIT_FILE   = "songs.mem",
  parameter int    SEL_W       = $clog2(NUM_SONGS),
  parameter int    IDX_W       = $clog2(SONG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  input  logic [SEL_W-1:0] song_sel,
  input  logic [1:0]       tempo_shift,
  output logic [7:0]       key_code,
  output logic             key_valid,
  output logic             key_released,
  output logic             busy,
  output logic             song_done,
  output logic [IDX_W-1:0] note_index
);

  localparam int ROM_N = NUM_SONGS * SONG_DEPTH;
  localparam int AW    = $clog2(ROM_N);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_PAUSED, S_DONE} state_t;

  state_t           state_r, state_n;
  logic [7:0]       rom [ROM_N];
  logic [7:0]       rom_q_r;
  logic [SEL_W-1:0] sel_r, rd_song;
  logic [IDX_W-1:0] idx_r, rd_idx;
  logic [AW-1:0]    rom_addr;
  logic [31:0]      p_r, cnt_r;
  logic [35:0]      len_r, len_n;
  logic [3:0]       l_eff;
  logic [2:0]       note_r;
  logic [7:0]       key_code_r;
  logic             loop_r, held_r, held_n, rel_pend_r;
  logic             in_slot, run, go, kill, onset, rel, last, end_next, advance;

  function automatic logic [7:0] note_code(input logic [2:0] note);
    case (note)
      3'd1:    note_code = 8'h1A;
      3'd2:    note_code = 8'h22;
      3'd3:    note_code = 8'h21;
      3'd4:    note_code = 8'h2A;
      3'd5:    note_code = 8'h32;
      3'd6:    note_code = 8'h31;
      3'd7:    note_code = 8'h3A;
      default: note_code = 8'h00;
    endcase
  endfunction

  // Slot decode; the ROM always looks one entry ahead so the next slot starts with no gap.
  always_comb begin
    in_slot  = (state_r == S_PLAY) || (state_r == S_PAUSED);
    run      = in_slot && !pause;
    go       = start && !stop;
    kill     = stop || go;
    onset    = run && (cnt_r == 32'd0) && (note_r != 3'd0);
    rel      = run && (note_r != 3'd0) && ({4'd0, cnt_r} == len_r - 36'(GAP_CYCLES));
    last     = run && ({4'd0, cnt_r} == len_r - 36'd1);
    end_next = rom_q_r[7] || (idx_r == IDX_W'(SONG_DEPTH - 1));
    advance  = last && !end_next && !kill;
    l_eff    = (rom_q_r[3:0] == 4'd0) ? 4'd1 : rom_q_r[3:0];
    len_n    = {4'd0, p_r} * {32'd0, l_eff};
    rd_song  = go ? song_sel : sel_r;
    rd_idx   = (in_slot && !go) ? idx_r + IDX_W'(1) : '0;
    rom_addr = AW'(rd_song) * AW'(SONG_DEPTH) + AW'(rd_idx);
    held_n   = onset ? 1'b1 : (rel ? 1'b0 : held_r);
  end

  // Synchronous ROM read.
  always_ff @(posedge clk) begin
    rom_q_r <= rom[rom_addr];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_n;
  end

  // Next-state logic; stop always wins over start.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:  state_n = go ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (stop)            state_n = S_IDLE;
        else if (go)         state_n = S_FETCH;
        else if (rom_q_r[7]) state_n = S_DONE;
        else                 state_n = S_PLAY;
      end
      S_PLAY, S_PAUSED: begin
        if (stop)                  state_n = S_IDLE;
        else if (go)               state_n = S_FETCH;
        else if (last && end_next) state_n = S_DONE;
        else if (pause)            state_n = S_PAUSED;
        else                       state_n = S_PLAY;
      end
      S_DONE: begin
        if (stop)           state_n = S_IDLE;
        else if (go)        state_n = S_FETCH;
        else if (loop_r)    state_n = S_FETCH;
        else                state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Slot counter, prefetched entry, latched settings and held-key tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r      <= '0;
      p_r        <= 32'd0;
      loop_r     <= 1'b0;
      key_code_r <= 8'h00;
      held_r     <= 1'b0;
      rel_pend_r <= 1'b0;
      idx_r      <= '0;
      note_r     <= 3'd0;
      len_r      <= 36'd0;
      cnt_r      <= 32'd0;
    end else begin
      if (go) begin
        sel_r <= song_sel;
        p_r   <= 32'(TICK_CYCLES) >> tempo_shift;
      end
      if (state_n == S_DONE) loop_r <= loop_en;
      if (onset) key_code_r <= note_code(note_r);
      held_r     <= kill ? 1'b0 : held_n;
      rel_pend_r <= kill && held_n;
      if (state_n == S_FETCH) begin
        idx_r <= '0;
      end else if (advance) begin
        idx_r  <= idx_r + IDX_W'(1);
        note_r <= rom_q_r[6:4];
        len_r  <= len_n;
        cnt_r  <= 32'd0;
      end else if (state_r == S_FETCH) begin
        note_r <= rom_q_r[6:4];
        len_r  <= len_n;
        cnt_r  <= 32'd0;
      end else if (run) begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    busy         = (state_r == S_FETCH) || in_slot;
    song_done    = (state_r == S_DONE);
    key_valid    = onset;
    key_released = rel || rel_pend_r;
    key_code     = onset ? note_code(note_r) : key_code_r;
    note_index   = idx_r;
  end

endmodule

// File: tb/tb_auto_play_seq.sv
// Directed bench for auto_play_seq with TICK_CYCLES=16, GAP_CYCLES=2 and a preloaded song ROM.
module tb_auto_play_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [1:0] song_sel = 2'd0, tempo_shift = 2'd0;
  logic [7:0] key_code;
  logic       key_valid, key_released, busy, song_done;
  logic [6:0] note_index;

  int checks = 0;
  int failures = 0;

  logic [127:0] obs_kv, obs_kr, obs_busy, obs_done;
  logic [7:0]   kc_log [128];
  logic [6:0]   idx_log [128];

  auto_play_seq #(
    .NUM_SONGS(4), .SONG_DEPTH(128), .TICK_CYCLES(16), .GAP_CYCLES(2), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .song_sel(song_sel), .tempo_shift(tempo_shift), .key_code(key_code),
    .key_valid(key_valid), .key_released(key_released), .busy(busy),
    .song_done(song_done), .note_index(note_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pulses(input int a, input int b, input int c);
    logic [127:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Runs n cycles from cycle t (index 0), recording outputs of each cycle.
  task automatic run(input bit do_start, input logic [1:0] sel, input logic [1:0] ts,
                     input bit lp, input int n, input int p_from, input int p_to,
                     input int stop_at);
    obs_kv = '0; obs_kr = '0; obs_busy = '0; obs_done = '0;
    for (int i = 0; i < n; i++) begin
      start       = do_start && (i == 0);
      song_sel    = sel;
      tempo_shift = ts;
      loop_en     = lp;
      pause       = (i >= p_from) && (i <= p_to);
      stop        = (i == stop_at);
      #1;
      obs_kv[i]   = key_valid;
      obs_kr[i]   = key_released;
      obs_busy[i] = busy;
      obs_done[i] = song_done;
      kc_log[i]   = key_code;
      idx_log[i]  = note_index;
      @(posedge clk);
      #1;
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) dut.rom[i] = 8'h80;
    dut.rom[0]   = 8'h12;
    dut.rom[1]   = 8'h51;
    dut.rom[2]   = 8'h01;
    dut.rom[3]   = 8'h80;
    dut.rom[128] = 8'h80;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_key_code", 128'(key_code), 128'h0);
    check("rst_key_valid", 128'(key_valid), 128'h0);
    check("rst_key_released", 128'(key_released), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_song_done", 128'(song_done), 128'h0);
    check("rst_note_index", 128'(note_index), 128'h0);

    // Song 0, normal tempo, one-shot.
    run(1'b1, 2'd0, 2'd0, 1'b0, 72, -1, -1, -1);
    check("a_kv", obs_kv, pulses(2, 34, -1));
    check("a_kr", obs_kr, pulses(32, 48, -1));
    check("a_done", obs_done, pulses(66, -1, -1));
    check("a_busy", obs_busy, span(1, 65));
    check("a_code2", 128'(kc_log[2]), 128'h1A);
    check("a_code34", 128'(kc_log[34]), 128'h32);
    check("a_code_rest", 128'(kc_log[55]), 128'h32);
    check("a_idx50", 128'(idx_log[50]), 128'd2);

    // Looping playback, then stop while the restarted note is held.
    run(1'b1, 2'd0, 2'd0, 1'b1, 72, -1, -1, -1);
    check("b_kv", obs_kv, pulses(2, 34, 68));
    check("b_kr", obs_kr, pulses(32, 48, -1));
    check("b_done", obs_done, pulses(66, -1, -1));
    check("b_busy", obs_busy, span(1, 65) | span(67, 71));
    check("b_code68", 128'(kc_log[68]), 128'h1A);
    check("b_idx68", 128'(idx_log[68]), 128'd0);
    run(1'b0, 2'd0, 2'd0, 1'b0, 3, -1, -1, 0);
    check("b_stop_kr", obs_kr, pulses(1, -1, -1));
    check("b_stop_busy", obs_busy, pulses(0, -1, -1));

    // Double tempo.
    run(1'b1, 2'd0, 2'd1, 1'b0, 40, -1, -1, -1);
    check("c_kv", obs_kv, pulses(2, 18, -1));
    check("c_kr", obs_kr, pulses(16, 24, -1));
    check("c_done", obs_done, pulses(34, -1, -1));

    // Pause for ten cycles inside the first note.
    run(1'b1, 2'd0, 2'd0, 1'b0, 80, 5, 14, -1);
    check("d_kv", obs_kv, pulses(2, 44, -1));
    check("d_kr", obs_kr, pulses(42, 58, -1));
    check("d_done", obs_done, pulses(76, -1, -1));

    // Stop while a key is held.
    run(1'b1, 2'd0, 2'd0, 1'b0, 30, -1, -1, 10);
    check("e_kv", obs_kv, pulses(2, -1, -1));
    check("e_kr", obs_kr, pulses(11, -1, -1));
    check("e_busy", obs_busy, span(1, 10));

    // Stop during the rest slot: nothing held, so no release.
    run(1'b1, 2'd0, 2'd0, 1'b0, 70, -1, -1, 55);
    check("f_kr", obs_kr, pulses(32, 48, -1));
    check("f_done", obs_done, 128'h0);
    check("f_busy", obs_busy, span(1, 55));

    // Asynchronous reset mid-cycle during playback.
    run(1'b1, 2'd0, 2'd0, 1'b0, 20, -1, -1, -1);
    check("g_code_before", 128'(kc_log[19]), 128'h1A);
    #1 rst = 1'b1;
    #1;
    check("g_code_rst", 128'(key_code), 128'h0);
    check("g_busy_rst", 128'(busy), 128'h0);
    check("g_idx_rst", 128'(note_index), 128'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(1'b0, 2'd0, 2'd0, 1'b0, 40, -1, -1, -1);
    check("g_kv_after", obs_kv, 128'h0);
    check("g_busy_after", obs_busy, 128'h0);

    // Song whose first entry is the end marker.
    run(1'b1, 2'd1, 2'd0, 1'b0, 10, -1, -1, -1);
    check("h_done", obs_done, pulses(2, -1, -1));
    check("h_kv", obs_kv, 128'h0);
    check("h_busy", obs_busy, pulses(1, -1, -1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/auto_play_seq.md
Name: auto_play_seq

Overview:
- Parametrised successor to the fixed-song auto player. Drives the piano keyboard path with synthetic key events (key_code, key_valid, key_released) from a multi-song ROM.
- Each note carries its own duration, and tempo is selectable. Supports start, stop, pause, loop and one-shot modes.
- Sits beside the PS/2 decoder. Its outputs are muxed into the same downstream note/tone logic.

Parameters:
- NUM_SONGS, 4, number of songs in ROM.
- SONG_DEPTH, 128, entries per song.
- TICK_CYCLES, 12_500_000, clk cycles per duration unit at tempo_shift=0. Must satisfy (TICK_CYCLES>>3) > GAP_CYCLES.
- GAP_CYCLES, 1_000_000, cycles between key release and the next note slot.
- INIT_FILE, "songs.mem", $readmemh image, NUM_SONGS*SONG_DEPTH bytes.
- Derived: SEL_W=clog2(NUM_SONGS), IDX_W=clog2(SONG_DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begin song song_sel from index 0
- stop  in  1  synchronous stop to IDLE
- pause  in  1  level; freezes playback
- loop_en  in  1  sampled at song end; 1 = restart song
- song_sel  in  SEL_W  song number, latched on accepted start
- tempo_shift  in  2  P = TICK_CYCLES >> tempo_shift, latched on start
- key_code  out  8  scan code of the current/last note
- key_valid  out  1  one-cycle onset pulse
- key_released  out  1  one-cycle release pulse
- busy  out  1  high in FETCH/PLAY/PAUSED
- song_done  out  1  one-cycle pulse at song end
- note_index  out  IDX_W  index of the entry currently playing

Behaviour:
- ROM entry byte layout:
  - [7] end marker
  - [6:4] note: 0 = rest; 1..7 map to 1A,22,21,2A,32,31,3A
  - [3:0] length L in units; L=0 is treated as 1
  - ROM address = song*SONG_DEPTH + index.
- Reset (async): state IDLE. All outputs 0: key_code=00, busy=0, note_index=0.
- States:
  - IDLE: start -> FETCH.
  - FETCH: 1 cycle, ROM read -> PLAY.
  - PLAY: pause -> PAUSED.
  - PAUSED: pause low -> PLAY.
- Latency: start sampled at cycle t -> busy=1 at t+1 -> onset at t+2.
- Note slot timing:
  - Slot lasts exactly L*P cycles, counter 0..L*P-1, counter 0 = onset cycle.
  - At counter 0, non-rest: key_valid=1, key_code updated.
  - At counter L*P-GAP_CYCLES: key_released=1.
  - Next slot's counter 0 immediately follows; the next entry is prefetched, so there are no gap cycles between slots.
- Rest: no key_valid, no key_released, key_code unchanged.
- End condition: the next entry is an end marker, or index would pass SONG_DEPTH-1.
  - Let E = final cycle of the last slot. song_done=1 and busy=0 at E+1.
  - loop_en=1 at E: treat E+1 as start; onset of entry 0 at E+3, busy back at E+2.
  - loop_en=0: go to IDLE.
- Pause:
  - Counter frozen and no pulses while pause=1.
  - A held key stays held (no release).
  - Resuming continues the count exactly; the slot is stretched by the pause length.
- Stop in FETCH/PLAY/PAUSED: IDLE next cycle, busy=0.
  - If a key is held (onset given, release not yet), key_released pulses at the next cycle.
- start while busy: behaves as stop then start. Optional release at t+1, new song onset at t+2.
- start and stop in the same cycle: stop wins.
- song_sel, tempo_shift and loop_en changes mid-play have no effect until the next latch point.
- pause in IDLE: ignored.
- Counter width: 32 bits. L*P is computed on a latched 36-bit product.

Test Plan (TICK_CYCLES=16, GAP_CYCLES=2; song0 = 12,51,01,80; song1 = 80):
- start at t, song0, tempo_shift=0, loop_en=0 -> required response:
  - key_valid at t+2, key_code=1A; key_released at t+32.
  - key_valid at t+34, key_code=32; key_released at t+48.
  - no pulses t+50..t+65; song_done at t+66, busy=0 from t+66.
- Same run with loop_en=1 -> song_done at t+66; key_valid (1A) at t+68; note_index=0.
- tempo_shift=1 (P=8) -> onsets at t+2 and t+18; first release at t+16.
- pause high for cycles t+5..t+14 (10 cycles) -> first release moves to t+42, second onset to t+44; no pulses during the pause.
- stop at t+10 -> key_released at t+11, busy=0 at t+11, no further pulses. Same stop during the rest slot -> no release pulse.
- rst asserted at t+20, asynchronously mid-cycle -> outputs zero immediately; after release, no activity until a new start.
- song1 (first entry is the end marker) -> song_done at t+2, no key_valid.
